// File: rtl/serial_code_tx.sv
// Serial code transmitter: shifts a latched access code out MSB-first to the lock,
// waits for the open/error verdict and keeps a saturating failure count with sticky lockout.
module serial_code_tx #(
  parameter int CODE_W    = 6,
  parameter int TIMEOUT   = 8,
  parameter int MAX_TRIES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CODE_W-1:0]                    code,
  input  logic                                 aberta_in,
  input  logic                                 erro_in,
  output logic                                 tx,
  output logic                                 tx_valid,
  output logic                                 busy,
  output logic                                 unlocked,
  output logic                                 failed,
  output logic                                 lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0]       fail_cnt
);

  localparam int BW = $clog2(CODE_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  localparam logic [BW-1:0] BITS_ALL  = BW'(CODE_W);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] TRIES_MAX = FW'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   sh_q, sh_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic                tx_q, tx_d;
  logic                txv_q, txv_d;
  logic                busy_q, busy_d;
  logic                unlocked_q, unlocked_d;
  logic                failed_q, failed_d;
  logic                lockout_q, lockout_d;
  logic [FW-1:0]       fail_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      timer_q    <= '0;
      fail_q     <= '0;
      tx_q       <= 1'b0;
      txv_q      <= 1'b0;
      busy_q     <= 1'b0;
      unlocked_q <= 1'b0;
      failed_q   <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      tx_q       <= tx_d;
      txv_q      <= txv_d;
      busy_q     <= busy_d;
      unlocked_q <= unlocked_d;
      failed_q   <= failed_d;
      lockout_q  <= lockout_d;
    end
  end

  assign fail_inc = (fail_q == TRIES_MAX) ? fail_q : fail_q + FW'(1);

  // Outputs are computed one cycle ahead so tx/tx_valid come straight from flops;
  // the first bit is therefore launched from `code` itself at the accepting edge.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    timer_d    = timer_q;
    fail_d     = fail_q;
    tx_d       = 1'b0;
    txv_d      = 1'b0;
    busy_d     = 1'b0;
    unlocked_d = 1'b0;
    failed_d   = 1'b0;
    lockout_d  = lockout_q;
    case (state_q)
      S_IDLE: begin
        if (start && !lockout_q) begin
          state_d = S_SEND;
          tx_d    = code[CODE_W-1];
          txv_d   = 1'b1;
          busy_d  = 1'b1;
          sh_d    = code << 1;
          bit_d   = BW'(1);
        end
      end
      S_SEND: begin
        busy_d = 1'b1;
        if (bit_q == BITS_ALL) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          tx_d  = sh_q[CODE_W-1];
          txv_d = 1'b1;
          sh_d  = sh_q << 1;
          bit_d = bit_q + BW'(1);
        end
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (aberta_in && !erro_in) begin
          unlocked_d = 1'b1;
          fail_d     = '0;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end else if (erro_in || (timer_q == TIMER_END)) begin
          fail_d = fail_inc;
          busy_d = 1'b0;
          if (fail_inc == TRIES_MAX) begin
            state_d   = S_LOCK;
            lockout_d = 1'b1;
          end else begin
            failed_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOCK: begin
        lockout_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_valid = txv_q;
  assign busy     = busy_q;
  assign unlocked = unlocked_q;
  assign failed   = failed_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_serial_code_tx.sv
// Directed, table-driven bench for serial_code_tx: each row is one clock cycle of
// inputs plus the outputs expected during that same cycle.
module tb_serial_code_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] code;
  logic       aberta_in;
  logic       erro_in;
  logic       tx;
  logic       tx_valid;
  logic       busy;
  logic       unlocked;
  logic       failed;
  logic       lockout;
  logic [1:0] fail_cnt;

  serial_code_tx #(.CODE_W(6), .TIMEOUT(8), .MAX_TRIES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .code      (code),
    .aberta_in (aberta_in),
    .erro_in   (erro_in),
    .tx        (tx),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .unlocked  (unlocked),
    .failed    (failed),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected vector packing: {tx, tx_valid, busy, unlocked, failed, lockout, fail_cnt[1:0]}
  typedef struct {
    logic       st;
    logic [5:0] cd;
    logic       ab;
    logic       er;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_n    = 0;

  function automatic logic [7:0] outs();
    return {tx, tx_valid, busy, unlocked, failed, lockout, fail_cnt};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got tx/v/busy/unl/fail/lock/cnt=%b required %b", nm, act, exp_v);
    end else begin
      $display("ok   %s: outputs %b", nm, act);
    end
  endtask

  task automatic add(input logic st, input logic [5:0] cd, input logic ab, input logic er,
                     input logic etx, input logic ev, input logic eb, input logic eu,
                     input logic ef, input logic el, input logic [1:0] efc);
    vec_t v;
    v.st    = st;
    v.cd    = cd;
    v.ab    = ab;
    v.er    = er;
    v.exp_o = {etx, ev, eb, eu, ef, el, efc};
    vq.push_back(v);
  endtask

  // six SEND cycles of code c, MSB first, with the failure count held at fc
  task automatic add_frame(input logic [5:0] c, input logic [1:0] fc);
    for (int k = 0; k < 6; k++) add(0, c, 0, 0, c[5-k], 1, 1, 0, 0, 0, fc);
  endtask

  // called at a falling edge: drive row inputs, compare this cycle's outputs, advance
  task automatic run();
    foreach (vq[i]) begin
      start     = vq[i].st;
      code      = vq[i].cd;
      aberta_in = vq[i].ab;
      erro_in   = vq[i].er;
      check($sformatf("row%0d", row_n), outs(), vq[i].exp_o);
      row_n++;
      @(posedge clk);
      @(negedge clk);
    end
    vq.delete();
    start     = 1'b0;
    aberta_in = 1'b0;
    erro_in   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; code = '0; aberta_in = 1'b0; erro_in = 1'b0;
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset_state", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // success on the first WAIT cycle
    add(1, 6'b101100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // erro in WAIT cycle 2
    add(1, 6'b101101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_frame(6'b101101, 2'd0);
    add(0, 6'b101101, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b101101, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b101101, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 6'b101101, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // no verdict: eight WAIT cycles then timeout
    add(1, 6'b101101, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add_frame(6'b101101, 2'd1);
    for (int j = 0; j < 8; j++) add(0, 6'b101101, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 6'b101101, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 6'b101101, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // third failure: lockout, no failed pulse, start ignored
    add(1, 6'b010101, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add_frame(6'b010101, 2'd2);
    add(0, 6'b010101, 0, 1, 0, 0, 1, 0, 0, 0, 2);
    add(1, 6'b010101, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 6'b010101, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(1, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 6'b111111, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    run();

    rst = 1'b0;
    #1 check("rst_clears_lockout", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // two failures (second frame back-to-back from the failed cycle), success, then one failure
    add(1, 6'b100001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_frame(6'b100001, 2'd0);
    add(0, 6'b100001, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 6'b011110, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add_frame(6'b011110, 2'd1);
    add(0, 6'b011110, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 6'b110011, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add_frame(6'b110011, 2'd2);
    add(0, 6'b110011, 1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(0, 6'b110011, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 6'b110011, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6'b000111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_frame(6'b000111, 2'd0);
    add(0, 6'b000111, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b000111, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 6'b000111, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // start held in cycles 2-4 with code changing mid-frame: frame bits unchanged
    add(1, 6'b110010, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 6'b110010, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(1, 6'b001101, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(1, 6'b001101, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 6'b001101, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 6'b001101, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 6'b001101, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 6'b001101, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    // start in the unlocked cycle: next frame's first bit one cycle later
    add(1, 6'b011011, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_frame(6'b011011, 2'd0);
    add(0, 6'b011011, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b011011, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 6'b011011, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // begin a frame to be aborted by reset in SEND cycle 3
    add(1, 6'b101100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 6'b101100, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    run();

    check("send_cycle3", outs(), 8'b1110_0000);
    rst = 1'b0;
    #1 check("async_abort", outs(), 8'h00);
    @(negedge clk);
    check("held_in_reset", outs(), 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // full frame from the MSB after reset, then both verdicts high -> failure
    add(1, 6'b110101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_frame(6'b110101, 2'd0);
    add(0, 6'b110101, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'b110101, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 6'b110101, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
